// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-set-2 and ASCII constants plus prefix FSM state encoding
package ps2_pkg;
  localparam logic [7:0] SC_BREAK    = 8'hF0;
  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_LSHIFT   = 8'h12;
  localparam logic [7:0] SC_RSHIFT   = 8'h59;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_BKSP     = 8'h66;
  localparam logic [7:0] SC_KP_SLASH = 8'h4A;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_SP    = 8'h20;
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
endpackage

// File: rtl/ps2_scan_lut.sv
// ps2_scan_lut: combinational scan-set-2 make code to ASCII table
module ps2_scan_lut
  import ps2_pkg::*;
(
  input  logic [7:0] scan_code,
  input  logic       extended,
  input  logic       upper,
  output logic [7:0] ascii,
  output logic       valid
);
  logic [7:0] base;
  logic       is_letter;
  always_comb begin
    base = 8'h00;
    if (extended)
      base = scan_code == SC_ENTER ? ASCII_LF : scan_code == SC_KP_SLASH ? 8'h2F : 8'h00;
    else
      case (scan_code)
        8'h1C: base = "a";
        8'h32: base = "b";
        8'h21: base = "c";
        8'h23: base = "d";
        8'h24: base = "e";
        8'h2B: base = "f";
        8'h34: base = "g";
        8'h33: base = "h";
        8'h43: base = "i";
        8'h3B: base = "j";
        8'h42: base = "k";
        8'h4B: base = "l";
        8'h3A: base = "m";
        8'h31: base = "n";
        8'h44: base = "o";
        8'h4D: base = "p";
        8'h15: base = "q";
        8'h2D: base = "r";
        8'h1B: base = "s";
        8'h2C: base = "t";
        8'h3C: base = "u";
        8'h2A: base = "v";
        8'h1D: base = "w";
        8'h22: base = "x";
        8'h35: base = "y";
        8'h1A: base = "z";
        8'h45: base = "0";
        8'h16: base = "1";
        8'h1E: base = "2";
        8'h26: base = "3";
        8'h25: base = "4";
        8'h2E: base = "5";
        8'h36: base = "6";
        8'h3D: base = "7";
        8'h3E: base = "8";
        8'h46: base = "9";
        8'h29: base = ASCII_SP;
        8'h49: base = ".";
        8'h4E: base = "-";
        SC_ENTER: base = ASCII_LF;
        SC_BKSP: base = ASCII_BS;
        default: base = 8'h00;
      endcase
  end
  assign is_letter = base >= "a" && base <= "z";
  assign ascii = is_letter && upper ? base - 8'h20 : base;
  assign valid = base != 8'h00;
endmodule

// File: rtl/ps2_keycode_decoder.sv
// ps2_keycode_decoder: PS/2 prefix FSM, shift/caps tracking and registered ASCII output
module ps2_keycode_decoder
  import ps2_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_ready,
  output logic [7:0] ascii_char,
  output logic       key_pressed,
  output logic       shift_active,
  output logic       caps_active
);
  state_t     state, next_state;
  logic       lshift, rshift, make, brk, ext, lut_valid;
  logic [7:0] lut_ascii;
  ps2_scan_lut lut (
    .scan_code(scan_code),
    .extended (ext),
    .upper    (shift_active ^ caps_active),
    .ascii    (lut_ascii),
    .valid    (lut_valid)
  );
  assign shift_active = lshift | rshift;
  always_comb begin
    next_state = state;
    make = 1'b0;
    brk = 1'b0;
    ext = 1'b0;
    if (scan_ready)
      case (state)
        IDLE: begin
          next_state = scan_code == SC_BREAK ? BRK : scan_code == SC_EXT ? EXT : IDLE;
          make = scan_code != SC_BREAK && scan_code != SC_EXT;
        end
        BRK: begin
          next_state = IDLE;
          brk = 1'b1;
        end
        EXT: begin
          next_state = scan_code == SC_BREAK ? EXT_BRK : IDLE;
          make = scan_code != SC_BREAK;
          ext = 1'b1;
        end
        default: begin
          next_state = IDLE;
          brk = 1'b1;
          ext = 1'b1;
        end
      endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ascii_char <= 8'h00;
      key_pressed <= 1'b0;
      lshift <= 1'b0;
      rshift <= 1'b0;
      caps_active <= 1'b0;
    end else begin
      state <= next_state;
      key_pressed <= make && lut_valid;
      if (make && lut_valid) ascii_char <= lut_ascii;
      if (!ext && (make || brk) && scan_code == SC_LSHIFT) lshift <= make;
      if (!ext && (make || brk) && scan_code == SC_RSHIFT) rshift <= make;
      if (!ext && make && scan_code == SC_CAPS) caps_active <= ~caps_active;
    end
  end
endmodule

// File: tb/tb_ps2_keycode_decoder.sv
// tb_ps2_keycode_decoder: directed self-checking bench for ps2_keycode_decoder
module tb_ps2_keycode_decoder;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_ready = 1'b0;
  logic [7:0] ascii_char;
  logic       key_pressed, shift_active, caps_active;
  int tests = 0;
  int failed = 0;
  ps2_keycode_decoder dut (
    .clock       (clock),
    .reset       (reset),
    .scan_code   (scan_code),
    .scan_ready  (scan_ready),
    .ascii_char  (ascii_char),
    .key_pressed (key_pressed),
    .shift_active(shift_active),
    .caps_active (caps_active)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask
  task automatic strobe(input logic [7:0] b);
    @(negedge clock);
    scan_code = b;
    scan_ready = 1'b1;
    @(negedge clock);
    scan_ready = 1'b0;
  endtask
  task automatic pulse(input string tag, input logic kp, input logic [7:0] ch);
    chk({tag, "_kp"}, {7'd0, key_pressed}, {7'd0, kp});
    chk({tag, "_ch"}, ascii_char, ch);
  endtask
  initial begin
    repeat (2) @(negedge clock);
    pulse("rst", 1'b0, 8'h00);
    chk("rst_shift", {7'd0, shift_active}, 8'h00);
    chk("rst_caps", {7'd0, caps_active}, 8'h00);
    reset = 1'b0;
    strobe(8'h1C); pulse("a", 1'b1, 8'h61);
    @(negedge clock); pulse("a_hold", 1'b0, 8'h61);
    strobe(8'h12); pulse("lsh_make", 1'b0, 8'h61);
    chk("lsh_on", {7'd0, shift_active}, 8'h01);
    strobe(8'h1C); pulse("A", 1'b1, 8'h41);
    strobe(8'hF0); pulse("brk_pfx", 1'b0, 8'h41);
    strobe(8'h1C); pulse("a_brk", 1'b0, 8'h41);
    chk("lsh_still", {7'd0, shift_active}, 8'h01);
    strobe(8'hF0); strobe(8'h12); pulse("lsh_brk", 1'b0, 8'h41);
    chk("lsh_off", {7'd0, shift_active}, 8'h00);
    strobe(8'h1C); pulse("a2", 1'b1, 8'h61);
    strobe(8'h59); chk("rsh_on", {7'd0, shift_active}, 8'h01);
    strobe(8'h1A); pulse("Z", 1'b1, 8'h5A);
    strobe(8'hF0); strobe(8'h59); chk("rsh_off", {7'd0, shift_active}, 8'h00);
    strobe(8'h58); chk("caps_on", {7'd0, caps_active}, 8'h01);
    chk("caps_kp", {7'd0, key_pressed}, 8'h00);
    strobe(8'hF0); strobe(8'h58); chk("caps_brk", {7'd0, caps_active}, 8'h01);
    strobe(8'h12); strobe(8'h1C); pulse("caps_xor", 1'b1, 8'h61);
    strobe(8'hF0); strobe(8'h12);
    strobe(8'h1C); pulse("caps_A", 1'b1, 8'h41);
    strobe(8'h16); pulse("caps_dig", 1'b1, 8'h31);
    strobe(8'h58); chk("caps_rep", {7'd0, caps_active}, 8'h00);
    strobe(8'h5A); pulse("enter", 1'b1, 8'h0A);
    strobe(8'h66); pulse("bksp", 1'b1, 8'h08);
    strobe(8'hE0); pulse("ext_pfx", 1'b0, 8'h08);
    strobe(8'h5A); pulse("ext_enter", 1'b1, 8'h0A);
    strobe(8'hE0); strobe(8'hF0); strobe(8'h5A); pulse("ext_brk", 1'b0, 8'h0A);
    strobe(8'h66); pulse("bksp2", 1'b1, 8'h08);
    strobe(8'hE0); strobe(8'h4A); pulse("kp_slash", 1'b1, 8'h2F);
    strobe(8'hE0); strobe(8'h1C); pulse("ext_ign", 1'b0, 8'h2F);
    strobe(8'hE0); strobe(8'h12); chk("ext_sh", {7'd0, shift_active}, 8'h00);
    strobe(8'h76); pulse("unmapped", 1'b0, 8'h2F);
    strobe(8'h45); pulse("zero", 1'b1, 8'h30);
    strobe(8'h29); pulse("space", 1'b1, 8'h20);
    strobe(8'h49); pulse("dot", 1'b1, 8'h2E);
    strobe(8'h4E); pulse("minus", 1'b1, 8'h2D);
    @(negedge clock); scan_code = 8'h16; scan_ready = 1'b1;
    @(negedge clock); scan_code = 8'h1E; pulse("b2b_1", 1'b1, 8'h31);
    @(negedge clock); scan_code = 8'h26; pulse("b2b_2", 1'b1, 8'h32);
    @(negedge clock); scan_ready = 1'b0; pulse("b2b_3", 1'b1, 8'h33);
    @(negedge clock); pulse("b2b_end", 1'b0, 8'h33);
    strobe(8'h1C); strobe(8'h1C); pulse("typem", 1'b1, 8'h61);
    strobe(8'h58); strobe(8'h12); strobe(8'hF0);
    @(negedge clock); reset = 1'b1; scan_code = 8'h1C; scan_ready = 1'b1;
    @(negedge clock); reset = 1'b0; scan_ready = 1'b0;
    pulse("rst2", 1'b0, 8'h00);
    chk("rst2_shift", {7'd0, shift_active}, 8'h00);
    chk("rst2_caps", {7'd0, caps_active}, 8'h00);
    strobe(8'h1C); pulse("post_rst", 1'b1, 8'h61);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
